// File: rtl/register_file_if.sv
// Register-file bus: write-back commit triple plus the two decode-stage read ports.
interface register_file_if;
  logic        wb_register_write_enable;
  logic [4:0]  wb_register_write_address;
  logic [31:0] wb_register_write_data;
  logic        read_enable_1;
  logic [4:0]  read_address_1;
  logic [31:0] read_data_1;
  logic        read_enable_2;
  logic [4:0]  read_address_2;
  logic [31:0] read_data_2;

  modport master (
    output wb_register_write_enable, wb_register_write_address, wb_register_write_data,
    output read_enable_1, read_address_1, read_enable_2, read_address_2,
    input  read_data_1, read_data_2
  );

  modport slave (
    input  wb_register_write_enable, wb_register_write_address, wb_register_write_data,
    input  read_enable_1, read_address_1, read_enable_2, read_address_2,
    output read_data_1, read_data_2
  );
endinterface

// File: rtl/register_file.sv
// 32x32 MIPS general-purpose register file: one write port, two combinational
// read ports with same-cycle write-back bypass; r0 is hardwired to zero.
module register_file (
  input  logic           clock,
  input  logic           reset,
  register_file_if.slave rf
);
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  logic [DATA_W-1:0] r_registers [NUM_REGS];
  logic              w_write_active;
  logic [DATA_W-1:0] w_read_data_1;
  logic [DATA_W-1:0] w_read_data_2;

  // Writes to r0 are dropped both for storage and for the bypass path.
  assign w_write_active = rf.wb_register_write_enable &&
                          (rf.wb_register_write_address != ADDR_W'(0));

  // Storage: reset clears everything and overrides a concurrent write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_registers[ADDR_W'(i)] <= '0;
      end
    end else if (w_write_active) begin
      r_registers[rf.wb_register_write_address] <= rf.wb_register_write_data;
    end
  end

  // Read port 1: reset, enable and r0 force zero; a matching write is bypassed.
  always_comb begin
    w_read_data_1 = '0;
    if (!reset && rf.read_enable_1 && (rf.read_address_1 != ADDR_W'(0))) begin
      if (w_write_active && (rf.wb_register_write_address == rf.read_address_1)) begin
        w_read_data_1 = rf.wb_register_write_data;
      end else begin
        w_read_data_1 = r_registers[rf.read_address_1];
      end
    end
  end

  // Read port 2: identical to port 1 and fully independent of it.
  always_comb begin
    w_read_data_2 = '0;
    if (!reset && rf.read_enable_2 && (rf.read_address_2 != ADDR_W'(0))) begin
      if (w_write_active && (rf.wb_register_write_address == rf.read_address_2)) begin
        w_read_data_2 = rf.wb_register_write_data;
      end else begin
        w_read_data_2 = r_registers[rf.read_address_2];
      end
    end
  end

  assign rf.read_data_1 = w_read_data_1;
  assign rf.read_data_2 = w_read_data_2;
endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file with hand-computed expectations.
module tb_register_file;
  logic clock;
  logic reset;
  register_file_if rf_if ();

  register_file dut (
    .clock (clock),
    .reset (reset),
    .rf    (rf_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2);
    reset                           = rst;
    rf_if.wb_register_write_enable  = we;
    rf_if.wb_register_write_address = waddr;
    rf_if.wb_register_write_data    = wdata;
    rf_if.read_enable_1             = re1;
    rf_if.read_address_1            = ra1;
    rf_if.read_enable_2             = re2;
    rf_if.read_address_2            = ra2;
  endtask

  function automatic logic [31:0] pattern(input int i);
    return (i == 0) ? 32'h0 : (32'(i) * 32'h01000193) ^ 32'hA5000000;
  endfunction

  initial begin
    // Each row is applied in its own cycle; rows before an edge commit on that edge.
    //         rst   we    waddr  wdata          re1   ra1    re2   ra2    exp1           exp2
    vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b1, 5'd6,  32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd6,  32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 5'd7,  32'h11111111, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 5'd7,  32'h22222222, 1'b1, 5'd7,  1'b1, 5'd7,  32'h22222222, 32'h22222222};
    vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'h22222222, 32'h22222222};
    vecs[5]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd5,  32'h0,        32'hDEADBEEF};
    vecs[7]  = '{1'b0, 1'b1, 5'd3,  32'h12345678, 1'b0, 5'd3,  1'b1, 5'd3,  32'h0,        32'h12345678};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  1'b1, 5'd3,  32'h0,        32'h12345678};
    vecs[9]  = '{1'b0, 1'b1, 5'd9,  32'h55555555, 1'b0, 5'd9,  1'b0, 5'd9,  32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd3,  32'h55555555, 32'h12345678};
    vecs[11] = '{1'b1, 1'b1, 5'd9,  32'hAAAAAAAA, 1'b1, 5'd9,  1'b1, 5'd5,  32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd9,  1'b1, 5'd5,  32'h0,        32'h0};
    vecs[13] = '{1'b0, 1'b1, 5'd31, 32'h0F0F0F0F, 1'b1, 5'd31, 1'b1, 5'd3,  32'h0F0F0F0F, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 1'b1, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[15] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[16] = '{1'b0, 1'b1, 5'd1,  32'h00000001, 1'b1, 5'd31, 1'b1, 5'd1,  32'hCAFEF00D, 32'h00000001};
    vecs[17] = '{1'b0, 1'b1, 5'd2,  32'h00000002, 1'b1, 5'd2,  1'b0, 5'd2,  32'h00000002, 32'h0};
    vecs[18] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b1, 5'd2,  32'h00000001, 32'h00000002};

    // Reset for one edge; reads are forced to zero while reset is high.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd8);
    #1;
    check("reset_hold_p1", rf_if.read_data_1, 32'h0);
    check("reset_hold_p2", rf_if.read_data_2, 32'h0);
    @(posedge clock);

    // Sweep every address on both ports after reset: all zero, no X.
    for (int a = 0; a < 32; a++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(31 - a));
      #1;
      check($sformatf("sweep_p1_r%0d", a), rf_if.read_data_1, 32'h0);
      check($sformatf("sweep_p2_r%0d", 31 - a), rf_if.read_data_2, 32'h0);
    end

    for (int v = 0; v < NVEC; v++) begin
      @(negedge clock);
      drive(vecs[v].rst, vecs[v].we, vecs[v].waddr, vecs[v].wdata,
            vecs[v].re1, vecs[v].ra1, vecs[v].re2, vecs[v].ra2);
      #1;
      check($sformatf("vec%0d_p1", v), rf_if.read_data_1, vecs[v].exp1);
      check($sformatf("vec%0d_p2", v), rf_if.read_data_2, vecs[v].exp2);
    end

    // Fill every register with a distinct pattern, then read them all back from storage.
    for (int a = 0; a < 32; a++) begin
      @(negedge clock);
      drive(1'b0, 1'b1, 5'(a), pattern(a) | ((a == 0) ? 32'hFFFFFFFF : 32'h0),
            1'b0, 5'd0, 1'b0, 5'd0);
    end
    for (int a = 0; a < 32; a++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(31 - a));
      #1;
      check($sformatf("fill_p1_r%0d", a), rf_if.read_data_1, pattern(a));
      check($sformatf("fill_p2_r%0d", 31 - a), rf_if.read_data_2, pattern(31 - a));
    end

    // Reset after the fill clears every register again.
    @(negedge clock);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b1, 5'd30);
    #1;
    check("refill_reset_p1", rf_if.read_data_1, 32'h0);
    check("refill_reset_p2", rf_if.read_data_2, 32'h0);
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b1, 5'd30);
    #1;
    check("post_reset_p1_r17", rf_if.read_data_1, 32'h0);
    check("post_reset_p2_r30", rf_if.read_data_2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
